dvfs_transition_sequencer: RTL

//   Sits directly downstream of the utilisation-based P-state selector. Takes its

---
 rtl/dvfs_transition_sequencer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/dvfs_transition_sequencer.sv
// DVFS transition sequencer: glitch-filters the requested (pstate, vcode) target,
// then applies it in a safe order (voltage up before frequency, frequency down
// before voltage), ramping the voltage code one LSB per settle interval.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | applied pair matches request (or disabled), waiting
// S_QUALIFY  | candidate target must stay unchanged STABLE_CYCLES cycles
// S_V_UP     | raising cur_vcode one step per VSTEP_CYCLES, freq unchanged
// S_F_SWITCH | freq_sel updated on entry, waiting FREQ_SETTLE cycles
// S_V_DOWN   | lowering cur_vcode one step per VSTEP_CYCLES after freq drop
// S_DONE     | one-cycle completion pulse, transition counter bump
module dvfs_transition_sequencer #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned VSTEP_CYCLES  = 16,
  parameter int unsigned FREQ_SETTLE   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [1:0]  target_pstate_i,
  input  logic [2:0]  target_vcode_i,
  output logic [2:0]  cur_vcode_o,
  output logic [1:0]  freq_sel_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] trans_count_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUALIFY,
    S_V_UP,
    S_F_SWITCH,
    S_V_DOWN,
    S_DONE
  } state_t;

  localparam logic [7:0] STABLE_LIM  = 8'(STABLE_CYCLES);
  localparam logic [7:0] VSTEP_LAST  = 8'(VSTEP_CYCLES - 1);
  localparam logic [7:0] FSETTLE_LAST = 8'(FREQ_SETTLE - 1);

  state_t      state_q, state_d;
  logic [1:0]  cand_p_q, cand_p_d;
  logic [2:0]  cand_v_q, cand_v_d;
  logic [7:0]  stab_cnt_q, stab_cnt_d;
  logic [1:0]  tgt_p_q, tgt_p_d;
  logic [2:0]  tgt_v_q, tgt_v_d;
  logic [7:0]  timer_q, timer_d;
  logic [2:0]  vcode_q, vcode_d;
  logic [1:0]  freq_q, freq_d;
  logic [15:0] count_q, count_d;

  logic        req_is_applied;
  logic        req_is_cand;
  logic [2:0]  vcode_inc;
  logic [2:0]  vcode_dec;

  assign req_is_applied = ({target_pstate_i, target_vcode_i} == {freq_q, vcode_q});
  assign req_is_cand    = ({target_pstate_i, target_vcode_i} == {cand_p_q, cand_v_q});
  assign vcode_inc      = vcode_q + 3'd1;
  assign vcode_dec      = vcode_q - 3'd1;

  // Next-state and datapath update for the sequencing FSM.
  always_comb begin
    state_d    = state_q;
    cand_p_d   = cand_p_q;
    cand_v_d   = cand_v_q;
    stab_cnt_d = stab_cnt_q;
    tgt_p_d    = tgt_p_q;
    tgt_v_d    = tgt_v_q;
    timer_d    = timer_q + 8'd1;
    vcode_d    = vcode_q;
    freq_d     = freq_q;
    count_d    = count_q;
    case (state_q)
      S_IDLE: begin
        timer_d = 8'd0;
        if (enable_i && !req_is_applied) begin
          cand_p_d   = target_pstate_i;
          cand_v_d   = target_vcode_i;
          stab_cnt_d = 8'd1;
          state_d    = S_QUALIFY;
        end
      end
      S_QUALIFY: begin
        timer_d = 8'd0;
        if (!enable_i || req_is_applied) begin
          state_d = S_IDLE;
        end else if (req_is_cand) begin
          if (stab_cnt_q >= STABLE_LIM) begin
            tgt_p_d = cand_p_q;
            tgt_v_d = cand_v_q;
            if (cand_v_q > vcode_q) begin
              state_d = S_V_UP;
            end else begin
              // Down or frequency-only path: frequency moves first.
              freq_d  = cand_p_q;
              state_d = S_F_SWITCH;
            end
          end else begin
            stab_cnt_d = stab_cnt_q + 8'd1;
          end
        end else begin
          cand_p_d   = target_pstate_i;
          cand_v_d   = target_vcode_i;
          stab_cnt_d = 8'd1;
        end
      end
      S_V_UP: begin
        if (vcode_q >= tgt_v_q) begin
          timer_d = 8'd0;
          freq_d  = tgt_p_q;
          state_d = S_F_SWITCH;
        end else if (timer_q >= VSTEP_LAST) begin
          timer_d = 8'd0;
          vcode_d = vcode_inc;
          if (vcode_inc == tgt_v_q) begin
            // Voltage is final, so the frequency may now be raised.
            freq_d  = tgt_p_q;
            state_d = S_F_SWITCH;
          end
        end
      end
      S_F_SWITCH: begin
        if (timer_q >= FSETTLE_LAST) begin
          timer_d = 8'd0;
          state_d = (vcode_q > tgt_v_q) ? S_V_DOWN : S_DONE;
        end
      end
      S_V_DOWN: begin
        if (vcode_q <= tgt_v_q) begin
          timer_d = 8'd0;
          state_d = S_DONE;
        end else if (timer_q >= VSTEP_LAST) begin
          timer_d = 8'd0;
          vcode_d = vcode_dec;
          if (vcode_dec == tgt_v_q) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        timer_d = 8'd0;
        if (count_q != 16'hFFFF) begin
          count_d = count_q + 16'd1;
        end
        state_d = S_IDLE;
      end
      default: begin
        timer_d = 8'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cand_p_q   <= 2'd0;
      cand_v_q   <= 3'd7;
      stab_cnt_q <= 8'd0;
      tgt_p_q    <= 2'd0;
      tgt_v_q    <= 3'd7;
      timer_q    <= 8'd0;
      vcode_q    <= 3'd7;
      freq_q     <= 2'd0;
      count_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      cand_p_q   <= cand_p_d;
      cand_v_q   <= cand_v_d;
      stab_cnt_q <= stab_cnt_d;
      tgt_p_q    <= tgt_p_d;
      tgt_v_q    <= tgt_v_d;
      timer_q    <= timer_d;
      vcode_q    <= vcode_d;
      freq_q     <= freq_d;
      count_q    <= count_d;
    end
  end

  assign cur_vcode_o   = vcode_q;
  assign freq_sel_o    = freq_q;
  assign busy_o        = (state_q == S_V_UP) || (state_q == S_F_SWITCH) ||
                         (state_q == S_V_DOWN) || (state_q == S_DONE);
  assign done_o        = (state_q == S_DONE);
  assign trans_count_o = count_q;

endmodule
